// File: rtl/prog_loader.sv
// prog_loader: streams bytes from a host link into the picoMIPS program
// memory. Bytes are packed MSB-first into instruction words and each word is
// written at the next address from 0. The CPU is held in reset for the
// duration of a load.
module prog_loader #(
    parameter int ADDR_WIDTH  = 6,
    parameter int INSTR_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   we,
    output logic [ADDR_WIDTH-1:0]  waddr,
    output logic [INSTR_WIDTH-1:0] wdata,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_WIDTH:0]    word_count
);

    localparam int BPW  = INSTR_WIDTH / 8;
    localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [IDXW-1:0]       LAST_IDX = IDXW'(BPW - 1);
    localparam logic [IDXW-1:0]       IDX_ONE  = IDXW'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDXW-1:0] byte_idx;
    logic            last_word;
    logic            accept;

    // A byte is consumed only while receiving; in_ready itself is purely a
    // function of state so there is no combinational path from the stream.
    assign accept   = (state == RECV) && in_valid;
    assign in_ready = (state == RECV);
    assign we       = (state == WRITE);
    assign done     = (state == DONE);
    assign cpu_hold = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: a full word goes to WRITE, a stream that ends
    // mid-word aborts straight to DONE, and a write of the last address or of
    // the word carrying in_last finishes the load.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (accept) begin
                    if (byte_idx == LAST_IDX) begin
                        state_next = WRITE;
                    end else if (in_last) begin
                        state_next = DONE;
                    end
                end
            end
            WRITE: begin
                if (last_word || (waddr == ADDR_MAX)) begin
                    state_next = DONE;
                end else begin
                    state_next = RECV;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: word assembly, byte index, address, word counter and the
    // sticky error flag. The address saturates at the top of memory so a
    // full load can never wrap around onto word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            waddr      <= '0;
            wdata      <= '0;
            byte_idx   <= '0;
            last_word  <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        waddr      <= '0;
                        wdata      <= '0;
                        byte_idx   <= '0;
                        last_word  <= 1'b0;
                        error      <= 1'b0;
                        word_count <= '0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        wdata <= INSTR_WIDTH'({wdata, in_data});
                        if (byte_idx == LAST_IDX) begin
                            byte_idx  <= '0;
                            last_word <= in_last;
                        end else if (in_last) begin
                            byte_idx <= '0;
                            error    <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + IDX_ONE;
                        end
                    end
                end
                WRITE: begin
                    word_count <= word_count + CNT_ONE;
                    if (waddr != ADDR_MAX) begin
                        waddr <= waddr + ADDR_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader. Table vectors,
// directed timing/reset sequences and randomized loads checked against a
// byte-stream reference model.
module tb_prog_loader;

    localparam int AW    = 6;
    localparam int IW    = 24;
    localparam int BPW   = IW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [IW-1:0] wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    int total = 0;
    int bad   = 0;

    prog_loader #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error),
        .word_count(word_count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Captured writes, done pulses and handshake/hold consistency.
    logic [AW-1:0] wrAddrQ[$];
    logic [IW-1:0] wrDataQ[$];
    int            doneCount = 0;
    int            holdBad   = 0;

    // Stimulus stream and reference-model results.
    logic [7:0]    stimData[$];
    bit            stimLast[$];
    logic [IW-1:0] expWords[$];

    typedef struct {
        string       name;
        int          len;
        logic [63:0] bytes;
        int          lastAt;
        int          gapPct;
        int          expWords;
        bit          expErr;
        logic [23:0] w0;
        logic [23:0] w1;
    } vec_t;

    vec_t vecs[6];

    // Sample outputs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wrAddrQ.push_back(waddr);
            wrDataQ.push_back(wdata);
        end
        if (done === 1'b1) doneCount++;
        if ((we === 1'b1 || done === 1'b1 || in_ready === 1'b1) && cpu_hold !== 1'b1) holdBad++;
        if (in_ready === 1'b1 && we === 1'b1) holdBad++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", name, actual, expected);
        end
    endtask

    // Reference model: cut the byte stream into BPW-byte words, stopping at
    // the first in_last or once the memory holds DEPTH words.
    task automatic modelLoad(output int nWords, output bit expErr, output int nAccepted);
        logic [31:0] word;
        int          k;
        expWords.delete();
        expErr    = 1'b0;
        nAccepted = 0;
        word      = 0;
        k         = 0;
        for (int i = 0; i < stimData.size(); i++) begin
            nAccepted++;
            word = word * 256 + 32'(stimData[i]);
            k++;
            if (k == BPW) begin
                expWords.push_back(IW'(word));
                word = 0;
                k    = 0;
                if (stimLast[i] || expWords.size() == DEPTH) break;
            end else if (stimLast[i]) begin
                expErr = 1'b1;
                break;
            end
        end
        nWords = expWords.size();
    endtask

    // Start a load and stream stimData with random valid gaps until done.
    task automatic applyStimulus(input string name, input int gapPct, output bit timedOut, output int accepted);
        int idx;
        bit acc;
        idx = 0;
        wrAddrQ.delete();
        wrDataQ.delete();
        doneCount = 0;
        holdBad   = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput({name, "_start_ready"}, {in_ready, cpu_hold, error}, 3'b110);
        timedOut = 1'b1;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (idx < stimData.size() && int'($urandom_range(99)) >= gapPct) begin
                in_valid = 1'b1;
                in_data  = stimData[idx];
                in_last  = stimLast[idx];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            if (done === 1'b1) begin
                timedOut = 1'b0;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        accepted = idx;
    endtask

    task automatic checkLoad(input string name, input bit timedOut, input int accepted);
        int nW;
        int nAcc;
        bit eErr;
        modelLoad(nW, eErr, nAcc);
        checkOutput({name, "_timeout"}, timedOut, 0);
        checkOutput({name, "_nwrites"}, wrAddrQ.size(), nW);
        for (int i = 0; i < nW && i < wrAddrQ.size(); i++) begin
            checkOutput({name, "_addr"}, wrAddrQ[i], i);
            checkOutput({name, "_data"}, wrDataQ[i], expWords[i]);
        end
        checkOutput({name, "_error"}, error, eErr);
        checkOutput({name, "_word_count"}, word_count, nW);
        checkOutput({name, "_accepted"}, accepted, nAcc);
        checkOutput({name, "_done_pulses"}, doneCount, 1);
        checkOutput({name, "_hold_consistency"}, holdBad, 0);
        checkOutput({name, "_hold_released"}, cpu_hold, 0);
    endtask

    task automatic loadVector(input vec_t v);
        stimData.delete();
        stimLast.delete();
        for (int k = 0; k < v.len; k++) begin
            stimData.push_back(v.bytes[63 - 8 * k -: 8]);
            stimLast.push_back(k == v.lastAt);
        end
    endtask

    task automatic checkIdle(input string name);
        checkOutput(name, {in_ready, we, cpu_hold, done, error, waddr, wdata, word_count}, 64'd0);
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit timedOut;
        int accepted;
        int nWordsR;
        int tail;

        vecs[0] = '{"two_word",  6, 64'h123456ABCDEF0000, 5, 0,  2, 1'b0, 24'h123456, 24'hABCDEF};
        vecs[1] = '{"gap_two",   6, 64'h123456ABCDEF0000, 5, 50, 2, 1'b0, 24'h123456, 24'hABCDEF};
        vecs[2] = '{"mid_word",  2, 64'h1122000000000000, 1, 0,  0, 1'b1, 24'h0,      24'h0};
        vecs[3] = '{"one_word",  3, 64'h0102030000000000, 2, 30, 1, 1'b0, 24'h010203, 24'h0};
        vecs[4] = '{"one_byte",  1, 64'h5A00000000000000, 0, 0,  0, 1'b1, 24'h0,      24'h0};
        vecs[5] = '{"tail_err",  8, 64'h1020304050607080, 7, 20, 2, 1'b1, 24'h102030, 24'h405060};

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        // Idle with in_valid held high: nothing moves.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkIdle("idle_outputs");
        end
        in_valid = 1'b0;
        checkOutput("idle_no_write", wrAddrQ.size(), 0);

        // Directed cycle timing of a two-word load with continuous valid.
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("t_start", {in_ready, cpu_hold, we, done}, 4'b1100);
        in_valid = 1'b1;
        in_data = 8'h12; tick();
        in_data = 8'h34; tick();
        in_data = 8'h56; tick();
        in_data = 8'hAB;
        checkOutput("t_write0", {we, in_ready, 6'(waddr), wdata}, {1'b1, 1'b0, 6'd0, 24'h123456});
        tick();
        checkOutput("t_ready_again", {in_ready, we}, 2'b10);
        tick();
        in_data = 8'hCD; tick();
        in_data = 8'hEF; in_last = 1'b1; tick();
        in_valid = 1'b0; in_last = 1'b0;
        checkOutput("t_write1", {we, 6'(waddr), wdata}, {1'b1, 6'd1, 24'hABCDEF});
        tick();
        checkOutput("t_done", {done, cpu_hold, we}, 3'b110);
        tick();
        checkOutput("t_idle", {done, cpu_hold, error, 7'(word_count)}, {3'b000, 7'd2});

        // Table vectors: constant expectations plus model cross-check.
        foreach (vecs[i]) begin
            loadVector(vecs[i]);
            applyStimulus(vecs[i].name, vecs[i].gapPct, timedOut, accepted);
            checkOutput({vecs[i].name, "_tbl_nwrites"}, wrAddrQ.size(), vecs[i].expWords);
            checkOutput({vecs[i].name, "_tbl_error"}, error, vecs[i].expErr);
            if (wrDataQ.size() > 0) checkOutput({vecs[i].name, "_tbl_w0"}, wrDataQ[0], vecs[i].w0);
            if (wrDataQ.size() > 1) checkOutput({vecs[i].name, "_tbl_w1"}, wrDataQ[1], vecs[i].w1);
            checkLoad(vecs[i].name, timedOut, accepted);
        end

        // Full memory: DEPTH*BPW bytes without in_last, plus one extra byte.
        stimData.delete();
        stimLast.delete();
        for (int i = 0; i < DEPTH * BPW + 1; i++) begin
            stimData.push_back(8'($urandom));
            stimLast.push_back(1'b0);
        end
        applyStimulus("full", 20, timedOut, accepted);
        checkLoad("full", timedOut, accepted);
        if (wrAddrQ.size() > 0) checkOutput("full_last_addr", wrAddrQ[wrAddrQ.size() - 1], DEPTH - 1);

        // Reset in the middle of a load, then a clean reload from address 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        accepted = 0;
        for (int cyc = 0; cyc < 50 && accepted < 4; cyc++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'b0;
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        checkIdle("reset_midload");
        reset = 1'b0;
        tick();
        loadVector(vecs[0]);
        applyStimulus("after_reset", 10, timedOut, accepted);
        checkLoad("after_reset", timedOut, accepted);

        // Randomized loads against the reference model.
        for (int r = 0; r < 6; r++) begin
            stimData.delete();
            stimLast.delete();
            nWordsR = int'($urandom_range(5, 1));
            tail    = int'($urandom_range(2, 0));
            for (int i = 0; i < nWordsR * BPW + tail; i++) begin
                stimData.push_back(8'($urandom));
                stimLast.push_back(i == nWordsR * BPW + tail - 1);
            end
            applyStimulus("rand", int'($urandom_range(50, 0)), timedOut, accepted);
            checkLoad("rand", timedOut, accepted);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
